sram_access_sequencer: RTL
==========================

Name: sram_access_sequencer

Overview:
- Timing controller directly upstream of the 6T bit-cell array in the sram_4kb_256x128x8 macro.
- Accepts one read or write request at a time from a valid/ready port.
- Sequences the array control signals: precharge, wordline enable, write_en and sense_en.
- Drives write data to the bitline drivers, captures sense-amp data, and returns a one-cycle response pulse.

Parameters:
- ADDR_W, 8: row address width; selects one wordline.
- DATA_W, 8: word width for write data, sense data and read data.
- PRE_CYC, 2: number of precharge cycles. Legal range 1..15.
- ACC_CYC, 2: number of wordline-active cycles before sense (read) or completion (write). Legal range 1..15.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  row address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_we  out  1  type of the completed operation.
- rsp_rdata  out  DATA_W  read data; holds its value until the next read completes.
- busy  out  1  high whenever the state is not IDLE.
- pre_n  out  1  bitline precharge, active-low.
- wl_addr  out  ADDR_W  registered row address to the wordline decoder.
- wl_en  out  1  wordline enable.
- write_en  out  1  array write enable.
- sense_en  out  1  sense-amp enable. Cells drive the bitlines only while sense_en=0.
- wdrv_data  out  DATA_W  registered write data to the bitline drivers.
- sa_data  in  DATA_W  sense-amp outputs; sampled only in SENSE.

Behaviour:
- Reset (rst_n=0 at a clock edge), on that edge regardless of state:
  - state <= IDLE.
  - req_ready=1 and pre_n=1.
  - wl_en, write_en, sense_en, rsp_valid, rsp_we, busy = 0.
  - wl_addr, wdrv_data, rsp_rdata = 0.
  - Counter cleared.
  - Reset mid-operation aborts the access and produces no response.
- FSM states: IDLE, PRE, ACC, SENSE, RECOVER.
- IDLE:
  - req_ready=1; all array controls inactive.
  - On req_valid && req_ready: register req_addr into wl_addr and req_wdata into wdrv_data, latch req_we, load counter = PRE_CYC-1, go to PRE.
  - Requests presented while not IDLE are ignored; req_ready=0 there.
- PRE:
  - pre_n=0.
  - Counts down; at 0, load counter = ACC_CYC-1 and go to ACC.
- ACC:
  - wl_en=1 and pre_n=1.
  - Write: write_en=1 and sense_en=0.
  - Read: write_en=0 and sense_en=0, so the cells develop the bitlines.
  - At count 0: reads go to SENSE, writes go to RECOVER.
- SENSE (reads only), 1 cycle:
  - wl_en=1, sense_en=1.
  - rsp_rdata <= sa_data at the end of this cycle.
- RECOVER, 1 cycle:
  - wl_en=0, write_en=0, sense_en=0.
  - rsp_valid=1, rsp_we = latched we.
  - Next state IDLE.
- Control-signal rule: every array control is a registered output. write_en and sense_en are never both 1.
- Timing with acceptance at edge 0:
  - Read: rsp_valid is high in cycle PRE_CYC+ACC_CYC+2 (cycle 6 at defaults).
  - Write: rsp_valid is high in cycle PRE_CYC+ACC_CYC+1 (cycle 5).
  - Next acceptance is possible in the cycle after RECOVER.
  - Throughput: one access per PRE_CYC+ACC_CYC+3 cycles (read) or PRE_CYC+ACC_CYC+2 cycles (write).
- Stability: wl_addr and wdrv_data stay stable from PRE entry until return to IDLE, even if the request inputs change.
- No response backpressure: rsp_valid is a pulse; the consumer must take it.
- rsp_rdata is unchanged by writes.
- Counter is 4 bits. Out-of-range parameter values are not supported.

Test Plan:
- Write then read, defaults:
  - Stimulus: write addr 0x05 data 0xA5; then read addr 0x05 with the sa_data model returning 0xA5 during SENSE.
  - Required: write rsp_valid at cycle 5 with rsp_we=1; read rsp_valid 6 cycles after its acceptance with rsp_we=0 and rsp_rdata=0xA5.
- Control sequence check, read addr 0xFF:
  - pre_n=0 for exactly 2 cycles.
  - Then wl_en=1 for 3 cycles, with sense_en=0,0,1.
  - wl_addr=0xFF throughout; write_en never 1.
- Request while busy:
  - Stimulus: hold req_valid=1 with a changing addr during an access.
  - Required: req_ready=0 and wl_addr unchanged; the second request is accepted only in the first IDLE cycle after RECOVER.
- Reset mid-access:
  - Stimulus: assert rst_n=0 during ACC.
  - Required: on the next edge wl_en=0, pre_n=1, no rsp_valid, state IDLE with req_ready=1.
- Parameter sweep PRE_CYC=1, ACC_CYC=4:
  - Read rsp_valid at cycle 7, write rsp_valid at cycle 6.
  - Back-to-back reads accepted every 8 cycles.
- Read data hold:
  - Stimulus: read returns 0x3C, then a write of 0x00 completes.
  - Required: rsp_rdata still 0x3C.

Source files
------------

// File: rtl/sram_access_sequencer.sv
// sram_access_sequencer
// Timing controller in front of the 6T bit-cell array. It accepts one
// read or write at a time. For each access it runs precharge, wordline
// and either write or sense, and then returns a one-cycle response pulse.
// Every array control is a registered output.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             request handshake
//   req_we, req_addr, req_wdata     request type, row address, write data
//   rsp_valid, rsp_we, rsp_rdata    completion pulse, op type, read data
//   busy                            high whenever not IDLE
//   pre_n, wl_addr, wl_en,          array controls: precharge (active-low),
//   write_en, sense_en, wdrv_data   row address, wordline, write/sense, write data
//   sa_data                         sense-amp outputs, sampled in SENSE
//
// state   | meaning
// IDLE    | ready for a request; all array controls inactive
// PRE     | bitlines precharging (pre_n low) for PRE_CYC cycles
// ACC     | wordline active for ACC_CYC cycles; write_en high on writes
// SENSE   | reads only: sense amps enabled, data captured at end of cycle
// RECOVER | wordline off; response pulse driven
module sram_access_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int PRE_CYC = 2,
    parameter int ACC_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              pre_n,
    output logic [ADDR_W-1:0] wl_addr,
    output logic              wl_en,
    output logic              write_en,
    output logic              sense_en,
    output logic [DATA_W-1:0] wdrv_data,
    input  logic [DATA_W-1:0] sa_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACC,
        S_SENSE,
        S_RECOVER
    } state_t;

    localparam logic [3:0] PRE_LOAD = 4'(PRE_CYC - 1);
    localparam logic [3:0] ACC_LOAD = 4'(ACC_CYC - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       we_q;
    logic       accept;

    assign accept = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_PRE;
                    cnt_d   = PRE_LOAD;
                end
            end
            S_PRE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACC;
                    cnt_d   = ACC_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACC: begin
                if (cnt_q == 4'd0) begin
                    state_d = we_q ? S_RECOVER : S_SENSE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SENSE:   state_d = S_RECOVER;
            S_RECOVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // The outputs are decoded from the next state and then registered, so
    // each control becomes valid in the same cycle as the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            pre_n     <= 1'b1;
            wl_en     <= 1'b0;
            write_en  <= 1'b0;
            sense_en  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            wl_addr   <= '0;
            wdrv_data <= '0;
            rsp_rdata <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wl_addr   <= req_addr;
                wdrv_data <= req_wdata;
                we_q      <= req_we;
            end
            req_ready <= (state_d == S_IDLE);
            busy      <= (state_d != S_IDLE);
            pre_n     <= (state_d != S_PRE);
            wl_en     <= (state_d == S_ACC) || (state_d == S_SENSE);
            // we_q is already settled here, because ACC is always entered from PRE.
            write_en  <= (state_d == S_ACC) && we_q;
            sense_en  <= (state_d == S_SENSE);
            rsp_valid <= (state_d == S_RECOVER);
            rsp_we    <= (state_d == S_RECOVER) && we_q;
            if (state_q == S_SENSE) begin
                rsp_rdata <= sa_data;
            end
        end
    end

endmodule
